// File: rtl/tilt_status_arbiter.sv
// Samples tilt and buttons once per period and publishes a packed status word
// into CPU RAM, borrowing the shared RAM port for a single stalled cycle.
module tilt_status_arbiter #(
  parameter int                ADDR_W       = 12,
  parameter int                DATA_W       = 32,
  parameter int                SAMPLE_DIV   = 100000,
  parameter int                CENTER_X     = 385,
  parameter int                CENTER_Y     = 80,
  parameter int                DEADBAND     = 8,
  parameter logic [ADDR_W-1:0] STATUS_ADDR  = 'hFF0,
  parameter int                STARVE_LIMIT = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [8:0]        accel_x,
  input  logic [8:0]        accel_y,
  input  logic              up_fpga,
  input  logic              down_fpga,
  input  logic              left_fpga,
  input  logic              right_fpga,
  input  logic              cpu_wren,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              cpu_stall,
  output logic [3:0]        dir
);

  localparam int TIMER_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int WAIT_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(SAMPLE_DIV - 1);
  localparam logic [WAIT_W-1:0]  WAIT_MAX  = WAIT_W'(STARVE_LIMIT - 1);

  // Lower bounds are only meaningful when the centre sits at least a deadband above zero.
  localparam bit         X_LO_OK = (CENTER_X >= DEADBAND);
  localparam bit         Y_LO_OK = (CENTER_Y >= DEADBAND);
  localparam logic [9:0] X_HI    = 10'(CENTER_X + DEADBAND);
  localparam logic [9:0] Y_HI    = 10'(CENTER_Y + DEADBAND);
  localparam logic [9:0] X_LO    = 10'(X_LO_OK ? CENTER_X - DEADBAND : 0);
  localparam logic [9:0] Y_LO    = 10'(Y_LO_OK ? CENTER_Y - DEADBAND : 0);

  typedef enum logic [1:0] {IDLE, PEND, WRITE} state_t;

  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic               tick;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [8:0]         seq;
  logic               overrun;
  logic [8:0]         snap_x;
  logic [8:0]         snap_y;
  logic [3:0]         btn_meta;
  logic [3:0]         btn_sync;
  logic [9:0]         x_ext;
  logic [9:0]         y_ext;
  logic [3:0]         sample_dir;
  logic [31:0]        status_word;

  assign tick  = (timer == TIMER_MAX);
  assign x_ext = {1'b0, accel_x};
  assign y_ext = {1'b0, accel_y};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer    <= '0;
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      timer    <= tick ? '0 : timer + 1'b1;
      btn_meta <= {up_fpga, down_fpga, left_fpga, right_fpga};
      btn_sync <= btn_meta;
    end
  end

  always_comb begin
    sample_dir    = '0;
    sample_dir[3] = (x_ext > X_HI) | btn_sync[3];
    sample_dir[2] = (X_LO_OK && (x_ext < X_LO)) | btn_sync[2];
    sample_dir[1] = (Y_LO_OK && (y_ext < Y_LO)) | btn_sync[1];
    sample_dir[0] = (y_ext > Y_HI) | btn_sync[0];
  end

  // The snapshot direction always equals dir, so dir doubles as the word's low nibble.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      seq      <= '0;
      overrun  <= 1'b0;
      dir      <= '0;
      snap_x   <= '0;
      snap_y   <= '0;
    end else begin
      if (tick) begin
        dir    <= sample_dir;
        snap_x <= accel_x;
        snap_y <= accel_y;
      end
      case (state)
        IDLE: begin
          if (tick) begin
            wait_cnt <= '0;
            state    <= PEND;
          end
        end
        PEND: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (tick) overrun <= 1'b1;
          if (!cpu_wren || (wait_cnt == WAIT_MAX)) state <= WRITE;
        end
        WRITE: begin
          seq     <= seq + 1'b1;
          overrun <= tick;
          if (tick) begin
            wait_cnt <= '0;
            state    <= PEND;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign status_word = {overrun, seq, snap_y, snap_x, dir};

  always_comb begin
    ram_wren  = cpu_wren;
    ram_addr  = cpu_addr;
    ram_data  = cpu_data;
    cpu_stall = 1'b0;
    if (state == WRITE) begin
      ram_wren  = 1'b1;
      ram_addr  = STATUS_ADDR;
      ram_data  = DATA_W'(status_word);
      cpu_stall = 1'b1;
    end
  end

endmodule

// File: tb/tb_tilt_status_arbiter.sv
// Randomised and directed bench for tilt_status_arbiter, checked every cycle
// against a sample/publish reference model kept in plain integers.
module tb_tilt_status_arbiter;

  localparam int SD = 16;
  localparam int SL = 20;
  localparam int CX = 385;
  localparam int CY = 80;
  localparam int DB = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [8:0]  accel_x = 9'd0;
  logic [8:0]  accel_y = 9'd0;
  logic        up_fpga = 1'b0, down_fpga = 1'b0, left_fpga = 1'b0, right_fpga = 1'b0;
  logic        cpu_wren = 1'b0;
  logic [11:0] cpu_addr = 12'h0;
  logic [31:0] cpu_data = 32'h0;
  logic        ram_wren;
  logic [11:0] ram_addr;
  logic [31:0] ram_data;
  logic        cpu_stall;
  logic [3:0]  dir;

  tilt_status_arbiter #(
    .ADDR_W(12), .DATA_W(32), .SAMPLE_DIV(SD), .CENTER_X(CX), .CENTER_Y(CY),
    .DEADBAND(DB), .STATUS_ADDR(12'hFF0), .STARVE_LIMIT(SL)
  ) dut (
    .clock(clock), .reset(reset), .accel_x(accel_x), .accel_y(accel_y),
    .up_fpga(up_fpga), .down_fpga(down_fpga), .left_fpga(left_fpga), .right_fpga(right_fpga),
    .cpu_wren(cpu_wren), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .ram_wren(ram_wren), .ram_addr(ram_addr), .ram_data(ram_data),
    .cpu_stall(cpu_stall), .dir(dir)
  );

  always #5 clock = ~clock;

  wire [49:0] obs_vec = {ram_wren, ram_addr, ram_data, cpu_stall, dir};

  int checks = 0;
  int errors = 0;

  // Reference model: a publish is "owed" after each sample until the port is won.
  int          m_timer, m_seq, m_over, m_waited, m_x, m_y, m_dir;
  bit          m_owed, m_writing;
  logic [3:0]  h1, h2;
  logic [49:0] exp_vec;
  int          dut_pubs = 0;
  int          dut_stalls = 0;
  logic [31:0] dut_last = 32'h0;

  function automatic logic [3:0] dir_rule(int x, int y, logic [3:0] b);
    logic [3:0] d;
    d[3] = (x > CX + DB) || b[3];
    d[2] = (x < CX - DB) || b[2];
    d[1] = (y < CY - DB) || b[1];
    d[0] = (y > CY + DB) || b[0];
    return d;
  endfunction

  task automatic model_clear();
    m_timer = 0; m_seq = 0; m_over = 0; m_waited = 0;
    m_x = 0; m_y = 0; m_dir = 0; m_owed = 0; m_writing = 0;
    h1 = 4'b0; h2 = 4'b0;
  endtask

  task automatic model_edge();
    bit         tk;
    logic [3:0] sdir;
    tk      = (m_timer == SD - 1);
    m_timer = (m_timer + 1) % SD;
    sdir    = dir_rule(accel_x, accel_y, h2);
    h2      = h1;
    h1      = {up_fpga, down_fpga, left_fpga, right_fpga};
    if (tk) begin
      m_dir = sdir; m_x = accel_x; m_y = accel_y;
    end
    if (m_writing) begin
      m_writing = 0;
      m_seq     = (m_seq + 1) % 512;
      m_over    = tk;
      if (tk) begin m_owed = 1; m_waited = 0; end
    end else if (m_owed) begin
      if (tk) m_over = 1;
      if (!cpu_wren || m_waited == SL - 1) begin
        m_owed = 0; m_writing = 1;
      end
      m_waited++;
    end else if (tk) begin
      m_owed = 1; m_waited = 0;
    end
  endtask

  task automatic step();
    logic [31:0] w;
    @(posedge clock);
    if (!reset) model_clear();
    else model_edge();
    #1;
    w = {m_over[0], 9'(m_seq), 9'(m_y), 9'(m_x), 4'(m_dir)};
    if (m_writing) exp_vec = {1'b1, 12'hFF0, w, 1'b1, 4'(m_dir)};
    else exp_vec = {cpu_wren, cpu_addr, cpu_data, 1'b0, 4'(m_dir)};
    if (cpu_stall) dut_stalls++;
    if (ram_wren && cpu_stall && ram_addr == 12'hFF0) begin
      dut_pubs++;
      dut_last = ram_data;
    end
  endtask

  task automatic test_reset();
    model_clear();
    cpu_wren = 1'b1; cpu_addr = 12'h3A5; cpu_data = 32'hDEADBEEF;
    #1 reset = 1'b0;
    #1;
    checks++;
    if (obs_vec !== {1'b1, 12'h3A5, 32'hDEADBEEF, 1'b0, 4'b0000}) begin
      errors++; $display("[TB] FAIL reset_state: got %h expected %h", obs_vec, {1'b1, 12'h3A5, 32'hDEADBEEF, 1'b0, 4'b0000});
    end
    repeat (3) begin
      step(); checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("[TB] FAIL reset_hold: got %h expected %h", obs_vec, exp_vec);
      end
    end
    cpu_wren = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_basic();
    int first_n = 0;
    logic [31:0] w1 = 32'h0, w2 = 32'h0;
    accel_x = 9'd400; accel_y = 9'd80; cpu_wren = 1'b0;
    for (int n = 1; n <= 2 * SD + 4; n++) begin
      cpu_addr = 12'($urandom); cpu_data = $urandom;
      step(); checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("[TB] FAIL basic_cycle: got %h expected %h", obs_vec, exp_vec);
      end
      if (dut_pubs == 1 && first_n == 0) begin first_n = n; w1 = dut_last; end
      if (dut_pubs == 2) w2 = dut_last;
    end
    checks++;
    if (first_n !== 17) begin
      errors++; $display("[TB] FAIL basic_latency: got cycle %0d expected 17", first_n);
    end
    checks++;
    if (w1 !== {1'b0, 9'd0, 9'd80, 9'd400, 4'b1000}) begin
      errors++; $display("[TB] FAIL basic_word0: got %h expected %h", w1, {1'b0, 9'd0, 9'd80, 9'd400, 4'b1000});
    end
    checks++;
    if (w2 !== {1'b0, 9'd1, 9'd80, 9'd400, 4'b1000}) begin
      errors++; $display("[TB] FAIL basic_word1: got %h expected %h", w2, {1'b0, 9'd1, 9'd80, 9'd400, 4'b1000});
    end
  endtask

  task automatic test_deadband();
    accel_x = 9'd393; accel_y = 9'd72;
    repeat (SD + 4) begin
      step(); checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("[TB] FAIL deadband_cycle: got %h expected %h", obs_vec, exp_vec);
      end
    end
    checks++;
    if (dir !== 4'b0000) begin
      errors++; $display("[TB] FAIL deadband_inside: got %b expected 0000", dir);
    end
    accel_x = 9'd394; accel_y = 9'd71;
    repeat (SD + 4) begin
      step(); checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("[TB] FAIL deadband_cycle: got %h expected %h", obs_vec, exp_vec);
      end
    end
    checks++;
    if (dir !== 4'b1010) begin
      errors++; $display("[TB] FAIL deadband_outside: got %b expected 1010", dir);
    end
  endtask

  task automatic test_buttons();
    accel_x = 9'd385; accel_y = 9'd80; left_fpga = 1'b1;
    repeat (SD + 4) begin
      step(); checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("[TB] FAIL buttons_cycle: got %h expected %h", obs_vec, exp_vec);
      end
    end
    checks++;
    if (dir !== 4'b0010) begin
      errors++; $display("[TB] FAIL buttons_left: got %b expected 0010", dir);
    end
    left_fpga = 1'b0;
  endtask

  task automatic test_starve_overrun();
    int  stalls0, pubs0, after;
    bit  aligned = 0;
    bit  prev_stall = 0;
    accel_x = 9'd400; accel_y = 9'd80; cpu_wren = 1'b0;
    for (int k = 0; k < 40 && !aligned; k++) begin
      step(); checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("[TB] FAIL starve_align: got %h expected %h", obs_vec, exp_vec);
      end
      aligned = (m_timer == 2) && !m_owed && !m_writing;
    end
    checks++;
    if (!aligned) begin
      errors++; $display("[TB] FAIL starve_align_timeout: got not aligned expected aligned");
    end
    stalls0 = dut_stalls; pubs0 = dut_pubs; after = -1;
    cpu_wren = 1'b1; cpu_addr = 12'h123; cpu_data = $urandom;
    for (int k = 1; k <= 60 && after != 0; k++) begin
      if (k == 15) accel_x = 9'd370;
      step(); checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("[TB] FAIL starve_cycle: got %h expected %h", obs_vec, exp_vec);
      end
      if (prev_stall) begin
        checks++;
        if ({ram_wren, ram_addr, ram_data} !== {1'b1, 12'h123, cpu_data}) begin
          errors++; $display("[TB] FAIL starve_cpu_replay: got %h expected %h", {ram_wren, ram_addr, ram_data}, {1'b1, 12'h123, cpu_data});
        end
      end
      prev_stall = cpu_stall;
      if (after > 0) after--;
      if (after < 0 && dut_pubs != pubs0) after = 1;
    end
    checks++;
    if (dut_stalls - stalls0 !== 1) begin
      errors++; $display("[TB] FAIL starve_stall_count: got %0d expected 1", dut_stalls - stalls0);
    end
    checks++;
    if ({dut_last[31], dut_last[12:4]} !== {1'b1, 9'd370}) begin
      errors++; $display("[TB] FAIL overrun_word: got %h expected bit31=1 x=370", dut_last);
    end
    cpu_wren = 1'b0; pubs0 = dut_pubs;
    for (int k = 0; k < 40 && dut_pubs == pubs0; k++) begin
      step(); checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("[TB] FAIL overrun_next_cycle: got %h expected %h", obs_vec, exp_vec);
      end
    end
    checks++;
    if (dut_pubs == pubs0 || dut_last[31] !== 1'b0) begin
      errors++; $display("[TB] FAIL overrun_clear: got %h expected bit31=0", dut_last);
    end
  endtask

  task automatic test_random();
    repeat (1500) begin
      accel_x = ($urandom_range(0, 7) == 0) ? 9'($urandom) : 9'($urandom_range(370, 400));
      accel_y = ($urandom_range(0, 7) == 0) ? 9'($urandom) : 9'($urandom_range(65, 95));
      up_fpga = ($urandom_range(0, 7) == 0); down_fpga = ($urandom_range(0, 7) == 0);
      left_fpga = ($urandom_range(0, 7) == 0); right_fpga = ($urandom_range(0, 7) == 0);
      cpu_wren = ($urandom_range(0, 3) != 0);
      cpu_addr = 12'($urandom); cpu_data = $urandom;
      step(); checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("[TB] FAIL random_cycle: got %h expected %h", obs_vec, exp_vec);
      end
    end
    {up_fpga, down_fpga, left_fpga, right_fpga} = 4'b0;
  endtask

  task automatic test_reset_mid_pend();
    int pubs0;
    accel_x = 9'd400; accel_y = 9'd80;
    cpu_wren = 1'b1; cpu_addr = 12'h055; cpu_data = 32'h12345678;
    for (int k = 0; k < 60 && !m_owed; k++) begin
      step(); checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("[TB] FAIL midreset_pre: got %h expected %h", obs_vec, exp_vec);
      end
    end
    reset = 1'b0;
    model_clear();
    #1;
    checks++;
    if (obs_vec !== {1'b1, 12'h055, 32'h12345678, 1'b0, 4'b0000}) begin
      errors++; $display("[TB] FAIL midreset_abandon: got %h expected %h", obs_vec, {1'b1, 12'h055, 32'h12345678, 1'b0, 4'b0000});
    end
    repeat (2) begin
      step(); checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("[TB] FAIL midreset_hold: got %h expected %h", obs_vec, exp_vec);
      end
    end
    reset = 1'b1; cpu_wren = 1'b0; pubs0 = dut_pubs;
    for (int k = 0; k < 40 && dut_pubs == pubs0; k++) begin
      step(); checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("[TB] FAIL midreset_after: got %h expected %h", obs_vec, exp_vec);
      end
    end
    checks++;
    if (dut_pubs == pubs0 || dut_last[31:22] !== 10'd0) begin
      errors++; $display("[TB] FAIL midreset_seq: got %h expected seq=0 overrun=0", dut_last);
    end
  endtask

  task automatic test_wrap();
    int  pubs0;
    bit  seen_wrap = 0;
    reset = 1'b0; model_clear();
    step(); step();
    reset = 1'b1; cpu_wren = 1'b0; pubs0 = dut_pubs;
    for (int k = 0; k < 513 * SD + 40 && !seen_wrap; k++) begin
      step(); checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("[TB] FAIL wrap_cycle: got %h expected %h", obs_vec, exp_vec);
      end
      if (cpu_stall && dut_pubs - pubs0 == 512) begin
        checks++;
        if (dut_last[30:22] !== 9'd511) begin
          errors++; $display("[TB] FAIL wrap_seq511: got %0d expected 511", dut_last[30:22]);
        end
      end
      if (cpu_stall && dut_pubs - pubs0 == 513) begin
        seen_wrap = 1; checks++;
        if (dut_last[30:22] !== 9'd0) begin
          errors++; $display("[TB] FAIL wrap_seq0: got %0d expected 0", dut_last[30:22]);
        end
      end
    end
    checks++;
    if (!seen_wrap) begin
      errors++; $display("[TB] FAIL wrap_timeout: got %0d publishes expected 513", dut_pubs - pubs0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_deadband();
    test_buttons();
    test_starve_overrun();
    test_random();
    test_reset_mid_pend();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
